// File: rtl/distance_stream_pkg.sv
// dist_pkg: shared state encoding and sizing helpers for the distance engine and its consumers
package dist_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int out_w(input int width, input int dim);
      return 2 * width + 1 + $clog2(dim);
   endfunction
   function automatic int beats(input int dim, input int lanes);
      return (dim + lanes - 1) / lanes;
   endfunction
endpackage

// File: rtl/distance_stream_lane_sum_tree.sv
// lane_sum_tree: combinational sum of LANES unsigned terms, widened to OUT_W
module lane_sum_tree #(
   parameter int LANES = 1,
   parameter int IN_W  = 65,
   parameter int OUT_W = 66
) (
   input  logic [IN_W-1:0]  terms [LANES],
   output logic [OUT_W-1:0] sum
);
   // reduction over all lanes; the flat sum leaves the tree shape to synthesis
   always_comb begin
      sum = '0;
      for (int i = 0; i < LANES; i++) sum = sum + OUT_W'(terms[i]);
   end
endmodule

// File: rtl/distance_stream.sv
// distance_stream: streaming squared-Euclidean distance engine; DIST_L1_EN adds a Manhattan metric select
module distance_stream
   import dist_pkg::*;
#(
   parameter int DIM   = 2,
   parameter int WIDTH = 32,
   parameter int LANES = 1,
   parameter int TAG_W = 8
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         in_valid_in,
   output logic                         in_ready_out,
   input  logic [WIDTH-1:0]             vertex_pos_in [DIM],
   input  logic [WIDTH-1:0]             query_pos_in [DIM],
   input  logic [TAG_W-1:0]             tag_in,
`ifdef DIST_L1_EN
   input  logic                         metric_l1_in,
`endif
   output logic [out_w(WIDTH, DIM)-1:0] distance_sq_out,
   output logic [TAG_W-1:0]             tag_out,
   output logic                         data_valid_out,
   input  logic                         out_ready_in
);
   localparam int OUT_W = out_w(WIDTH, DIM);
   localparam int BEATS = beats(DIM, LANES);
   localparam int TOT   = BEATS * LANES;
   localparam int SQ_W  = 2 * WIDTH + 1;
   localparam int CNT_W = $clog2(BEATS + 3);
   localparam logic [CNT_W-1:0] ACC_LO = CNT_W'(2);
   localparam logic [CNT_W-1:0] ACC_HI = CNT_W'(BEATS + 1);
   localparam logic [CNT_W-1:0] FINAL  = CNT_W'(BEATS + 2);
   state_t                 state, nxt;
   logic                   accept;
   logic [CNT_W-1:0]       cnt;
   logic [OUT_W-1:0]       acc, lane_sum;
   logic [TOT*WIDTH-1:0]   q_p, v_p, q_s, v_s;
   logic [SQ_W-1:0]        terms [LANES];
`ifdef DIST_L1_EN
   logic                   l1_r;
`endif
   assign in_ready_out    = state == IDLE || (state == DONE && out_ready_in);
   assign accept          = in_ready_out && in_valid_in;
   assign data_valid_out  = state == DONE;
   assign distance_sq_out = acc;
   for (genvar i = 0; i < TOT; i++) begin : g_pack
      if (i < DIM) begin : g_dim
         assign q_p[i*WIDTH +: WIDTH] = query_pos_in[i];
         assign v_p[i*WIDTH +: WIDTH] = vertex_pos_in[i];
      end else begin : g_pad
         assign q_p[i*WIDTH +: WIDTH] = '0;
         assign v_p[i*WIDTH +: WIDTH] = '0;
      end
   end
   // next state: accept wins from IDLE or a consumed DONE, RUN ends once the last beat is summed
   always_comb begin
      nxt = state;
      if (accept) nxt = RUN;
      else if (state == RUN && cnt == FINAL) nxt = DONE;
      else if (state == DONE && out_ready_in) nxt = IDLE;
   end
   // state, cycle counter, accumulator and result tag
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         tag_out <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            cnt     <= '0;
            acc     <= '0;
            tag_out <= tag_in;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (cnt >= ACC_LO && cnt <= ACC_HI) acc <= acc + lane_sum;
         end
      end
   end
   // captured operands shift down one beat per RUN cycle; zero padding makes spare lanes contribute nothing
   always_ff @(posedge clk_in) begin
      if (accept) begin
         q_s <= q_p;
         v_s <= v_p;
`ifdef DIST_L1_EN
         l1_r <= metric_l1_in;
`endif
      end else if (state == RUN) begin
         q_s <= q_s >> (LANES * WIDTH);
         v_s <= v_s >> (LANES * WIDTH);
      end
   end
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0]          q, v;
      logic signed [WIDTH:0]     diff;
      logic signed [2*WIDTH+1:0] dx;
      logic [SQ_W-1:0]           sq;
      assign q        = q_s[l*WIDTH +: WIDTH];
      assign v        = v_s[l*WIDTH +: WIDTH];
      assign dx       = {{(WIDTH + 1){diff[WIDTH]}}, diff};
      assign terms[l] = sq;
`ifdef DIST_L1_EN
      logic [WIDTH:0] mag;
      assign mag = diff[WIDTH] ? -diff : diff;
      // stage 1 sign-extended difference, stage 2 square or magnitude
      always_ff @(posedge clk_in) begin
         diff <= {q[WIDTH-1], q} - {v[WIDTH-1], v};
         sq   <= l1_r ? SQ_W'(mag) : SQ_W'(dx * dx);
      end
`else
      // stage 1 sign-extended difference, stage 2 exact square
      always_ff @(posedge clk_in) begin
         diff <= {q[WIDTH-1], q} - {v[WIDTH-1], v};
         sq   <= SQ_W'(dx * dx);
      end
`endif
   end
   lane_sum_tree #(.LANES(LANES), .IN_W(SQ_W), .OUT_W(OUT_W)) u_tree (
      .terms (terms),
      .sum   (lane_sum)
   );
endmodule

// File: tb/tb_distance_stream.sv
// tb_distance_stream: scoreboard bench for two distance_stream configurations
module tb_distance_stream;
   logic clk = 0, rst = 1;
   int   checks = 0, errors = 0, cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   logic        a_iv = 0, a_ir, a_dv, a_or = 1, a_l1 = 0, a_dv_prev = 0;
   logic [31:0] a_q [2], a_v [2];
   logic [7:0]  a_tag = 0, a_tago;
   logic [65:0] a_dist;
   logic        b_iv = 0, b_ir, b_dv, b_or = 1, b_dv_prev = 0;
   logic [15:0] b_q [3], b_v [3];
   logic [7:0]  b_tag = 0, b_tago;
   logic [34:0] b_dist;
   logic [127:0] a_exp [$], b_exp [$];
   logic [7:0]   a_texp [$], b_texp [$];
   int           a_tacc [$], b_tacc [$];
   distance_stream #(.DIM(2), .WIDTH(32), .LANES(1), .TAG_W(8)) dut_a (
      .clk_in(clk), .rst_in(rst), .in_valid_in(a_iv), .in_ready_out(a_ir),
      .vertex_pos_in(a_v), .query_pos_in(a_q), .tag_in(a_tag),
`ifdef DIST_L1_EN
      .metric_l1_in(a_l1),
`endif
      .distance_sq_out(a_dist), .tag_out(a_tago), .data_valid_out(a_dv), .out_ready_in(a_or));
   distance_stream #(.DIM(3), .WIDTH(16), .LANES(2), .TAG_W(8)) dut_b (
      .clk_in(clk), .rst_in(rst), .in_valid_in(b_iv), .in_ready_out(b_ir),
      .vertex_pos_in(b_v), .query_pos_in(b_q), .tag_in(b_tag),
`ifdef DIST_L1_EN
      .metric_l1_in(1'b0),
`endif
      .distance_sq_out(b_dist), .tag_out(b_tago), .data_valid_out(b_dv), .out_ready_in(b_or));
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic [127:0] term(input logic signed [63:0] d, input logic l1);
      logic signed [127:0] x;
      x = d;
      return l1 ? (x < 0 ? -x : x) : x * x;
   endfunction
   function automatic logic [127:0] model_a();
      logic [127:0] s = 0;
      for (int i = 0; i < 2; i++) s += term(longint'($signed(a_q[i])) - longint'($signed(a_v[i])), a_l1);
      return s;
   endfunction
   function automatic logic [127:0] model_b();
      logic [127:0] s = 0;
      for (int i = 0; i < 3; i++) s += term(longint'($signed(b_q[i])) - longint'($signed(b_v[i])), 1'b0);
      return s;
   endfunction
   always @(negedge clk) begin
      if (rst) begin
         a_exp.delete(); a_texp.delete(); a_tacc.delete();
      end else begin
         if (a_iv && a_ir) begin
            a_exp.push_back(model_a()); a_texp.push_back(a_tag); a_tacc.push_back(cyc + 1);
         end
         if (a_dv && !a_dv_prev) begin
            if (a_tacc.size() == 0) check("a_spurious_valid", 1, 0);
            else check("a_latency", cyc - a_tacc.pop_front(), 5);
         end
         if (a_dv && a_or) begin
            if (a_exp.size() == 0) check("a_unexpected", 1, 0);
            else begin
               check("a_dist", a_dist, a_exp.pop_front());
               check("a_tag", a_tago, a_texp.pop_front());
            end
         end
      end
      a_dv_prev = a_dv;
   end
   always @(negedge clk) begin
      if (rst) begin
         b_exp.delete(); b_texp.delete(); b_tacc.delete();
      end else begin
         if (b_iv && b_ir) begin
            b_exp.push_back(model_b()); b_texp.push_back(b_tag); b_tacc.push_back(cyc + 1);
         end
         if (b_dv && !b_dv_prev) begin
            if (b_tacc.size() == 0) check("b_spurious_valid", 1, 0);
            else check("b_latency", cyc - b_tacc.pop_front(), 5);
         end
         if (b_dv && b_or) begin
            if (b_exp.size() == 0) check("b_unexpected", 1, 0);
            else begin
               check("b_dist", b_dist, b_exp.pop_front());
               check("b_tag", b_tago, b_texp.pop_front());
            end
         end
      end
      b_dv_prev = b_dv;
   end
   task automatic send_a(input logic [31:0] q0, q1, v0, v1, input logic [7:0] tag, input logic l1);
      int n = 0;
      a_q[0] = q0; a_q[1] = q1; a_v[0] = v0; a_v[1] = v1; a_tag = tag; a_l1 = l1; a_iv = 1;
      @(negedge clk);
      while (!a_ir && n < 50) begin n++; @(negedge clk); end
      check("a_accept", a_ir, 1);
      @(posedge clk); #1;
      a_iv = 0; a_q[0] = $urandom(); a_v[1] = $urandom(); a_tag = 8'hEE; a_l1 = 0;
   endtask
   task automatic send_b(input logic [15:0] q0, q1, q2, v0, v1, v2, input logic [7:0] tag);
      int n = 0;
      b_q[0] = q0; b_q[1] = q1; b_q[2] = q2; b_v[0] = v0; b_v[1] = v1; b_v[2] = v2; b_tag = tag; b_iv = 1;
      @(negedge clk);
      while (!b_ir && n < 50) begin n++; @(negedge clk); end
      check("b_accept", b_ir, 1);
      @(posedge clk); #1;
      b_iv = 0; b_q[2] = 16'($urandom()); b_v[0] = 16'($urandom()); b_tag = 8'hEE;
   endtask
   task automatic drain();
      int n = 0;
      while ((a_exp.size() + b_exp.size()) != 0 && n < 300) begin n++; @(posedge clk); end
      #1;
      check("drain", a_exp.size() + b_exp.size(), 0);
   endtask
   task automatic check_reset_values();
      check("rst_a_ready", a_ir, 1);
      check("rst_a_valid", a_dv, 0);
      check("rst_a_dist", a_dist, 0);
      check("rst_a_tag", a_tago, 0);
      check("rst_b_ready", b_ir, 1);
      check("rst_b_valid", b_dv, 0);
      check("rst_b_dist", b_dist, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      for (int i = 0; i < 2; i++) begin a_q[i] = 0; a_v[i] = 0; end
      for (int i = 0; i < 3; i++) begin b_q[i] = 0; b_v[i] = 0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      @(posedge clk); #1 rst = 0;
      send_a(32'd5, 32'd7, 32'd2, 32'd3, 8'h5A, 1'b0);
      send_b(16'h8000, 16'h0000, 16'd10, 16'h7FFF, 16'h0000, 16'hFFF6, 8'hC3);
      drain();
      a_or = 0;
      send_a(32'd5, 32'd7, 32'd2, 32'd3, 8'h11, 1'b0);
      n = 0;
      @(negedge clk);
      while (!a_dv && n < 20) begin n++; @(negedge clk); end
      check("bp_valid_seen", a_dv, 1);
      repeat (10) begin
         check("bp_dist", a_dist, 25);
         check("bp_tag", a_tago, 8'h11);
         check("bp_ready", a_ir, 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      a_or = 1; a_q[0] = 5; a_q[1] = 7; a_v[0] = 2; a_v[1] = 3; a_tag = 8'h12; a_iv = 1;
      @(negedge clk);
      check("bp_same_cycle_accept", a_ir, 1);
      @(posedge clk); #1 a_iv = 0;
      drain();
      for (int t = 0; t < 8; t++) send_a($urandom(), $urandom(), $urandom(), $urandom(), 8'(t), 1'b0);
      for (int t = 0; t < 4; t++)
         send_b(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()), 8'(t + 16));
      drain();
      send_a(32'd5, 32'd7, 32'd2, 32'd3, 8'h77, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check_reset_values();
      repeat (10) begin @(negedge clk); check("rst_no_valid", a_dv, 0); end
      @(posedge clk); #1;
      send_a(32'd9, 32'hFFFF_FFFE, 32'd4, 32'd1, 8'h78, 1'b0);
      drain();
`ifdef DIST_L1_EN
      send_a(32'd5, 32'hFFFF_FFF9, 32'd2, 32'd3, 8'h13, 1'b1);
      drain();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
